// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences ALU, IR, PC and the shared memory port.
// Define ILLEGAL_OP_TRAP_EN to trap unknown opcodes into HALT and expose the sticky illegal_op flag.
module mips_multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       memtoreg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       halted,
   output logic       mem_err,
`ifdef ILLEGAL_OP_TRAP_EN
   output logic       illegal_op,
`endif
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_HALT   = 4'd15
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       mem_err_q, mem_err_d;
   logic       ill_q, ill_d;
   logic       wait_mem;
   logic       timeout;

   // This waiting cycle is the MEM_TIMEOUT-th without mem_ready.
   assign timeout = ({1'b0, cnt_q} + 9'd1) >= 9'(MEM_TIMEOUT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         cnt_q     <= 8'd0;
         mem_err_q <= 1'b0;
         ill_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_d;
         ill_q     <= ill_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = 8'd0;
      mem_err_d = mem_err_q;
      ill_d     = ill_q;
      wait_mem  = 1'b0;
      mem_req   = 1'b0;
      mem_write = 1'b0;
      iord      = 1'b0;
      ir_write  = 1'b0;
      reg_dst   = 1'b0;
      memtoreg  = 1'b0;
      reg_write = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      alu_op    = 2'b00;
      pc_src    = 2'b00;
      pc_en     = 1'b0;
      halted    = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_en     = mem_ready;
            wait_mem  = 1'b1;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
               default: begin
                  state_d = S_HALT;
                  ill_d   = 1'b1;
               end
`else
               default:      state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (opcode == OP_SW)      state_d = S_MEMWR;
            else if (opcode == OP_LW) state_d = S_MEMRD;
            else                      state_d = S_FETCH;
         end
         S_MEMRD: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            wait_mem = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWR: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            iord      = 1'b1;
            wait_mem  = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_MEMWB: begin
            reg_write = 1'b1;
            memtoreg  = 1'b1;
            state_d   = S_FETCH;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            pc_en     = zero;
            state_d   = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_src  = 2'b10;
            pc_en   = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: begin
            halted  = 1'b1;
            state_d = S_HALT;
         end
         default: state_d = S_FETCH;
      endcase

      // mem_ready in the same cycle as the limit wins, since this only fires while waiting.
      if (wait_mem && !mem_ready) begin
         if (timeout) begin
            state_d   = S_HALT;
            mem_err_d = 1'b1;
         end else begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
         end
      end
   end

   assign mem_err = mem_err_q;
   assign state   = state_q;
`ifdef ILLEGAL_OP_TRAP_EN
   assign illegal_op = ill_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: an instruction-level plan model predicts every cycle's outputs.
module tb_mips_multicycle_ctrl;

   localparam int TO = 4;
   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_write, iord, ir_write, reg_dst, memtoreg, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic       pc_en, halted, mem_err;
   logic [3:0] state;
`ifdef ILLEGAL_OP_TRAP_EN
   logic       illegal_op;
`endif

   mips_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
      .reg_dst(reg_dst), .memtoreg(memtoreg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en),
      .halted(halted), .mem_err(mem_err),
`ifdef ILLEGAL_OP_TRAP_EN
      .illegal_op(illegal_op),
`endif
      .state(state)
   );

   always #5 clk = ~clk;

   logic [20:0] dut_vec;
   assign dut_vec = {mem_req, mem_write, iord, ir_write, reg_dst, memtoreg, reg_write, alu_src_a,
                     alu_src_b, alu_op, pc_src, pc_en, halted, mem_err, state};

   int n_cmp = 0, n_bad = 0;

   // Model: current state number, the remaining states of the instruction, and wait bookkeeping.
   int  m_st = 0;
   int  m_wait = 0;
   bit  m_err = 0, m_ill = 0;
   int  plan[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [20:0] exp_vec(input int st, input logic mr, input logic z, input logic err);
      logic req = 0, wr = 0, io = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, pe = 0, hl = 0;
      logic [1:0] sb = 2'b00, op = 2'b00, ps = 2'b00;
      case (st)
         0:  begin req = 1; sb = 2'b01; irw = mr; pe = mr; end
         1:  sb = 2'b11;
         2:  begin sa = 1; sb = 2'b10; end
         3:  begin req = 1; io = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin req = 1; wr = 1; io = 1; end
         6:  begin sa = 1; op = 2'b10; end
         7:  begin rw = 1; rd = 1; end
         8:  begin sa = 1; op = 2'b01; ps = 2'b01; pe = z; end
         9:  begin sa = 1; sb = 2'b10; end
         10: rw = 1;
         11: begin ps = 2'b10; pe = 1; end
         15: hl = 1;
         default: ;
      endcase
      return {req, wr, io, irw, rd, m2r, rw, sa, sb, op, ps, pe, hl, err, 4'(st)};
   endfunction

   task automatic model_decode(input logic [5:0] op);
      plan.delete();
      case (op)
         LW:   plan = '{2, 3, 4};
         SW:   plan = '{2, 5};
         RT:   plan = '{6, 7};
         BEQ:  plan = '{8};
         ADDI: plan = '{9, 10};
         J:    plan = '{11};
         default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            plan = '{15};
            m_ill = 1;
`endif
         end
      endcase
   endtask

   task automatic model_step(input logic mr, input logic [5:0] op);
      if (m_st == 15) return;
      if ((m_st == 0 || m_st == 3 || m_st == 5) && !mr) begin
         m_wait++;
         if (m_wait >= TO) begin
            m_err = 1;
            m_st  = 15;
         end
         return;
      end
      m_wait = 0;
      if (m_st == 1) model_decode(op);
      if (m_st == 0) m_st = 1;
      else if (plan.size() > 0) m_st = plan.pop_front();
      else m_st = 0;
   endtask

   // Called at a falling edge; compares this cycle, then lets the clock advance one cycle.
   task automatic cycle(input logic mr, input logic z, input logic [5:0] op);
      mem_ready = mr;
      zero      = z;
      opcode    = op;
      #1;
      chk("outputs", 32'(dut_vec), 32'(exp_vec(m_st, mr, z, m_err)));
`ifdef ILLEGAL_OP_TRAP_EN
      chk("illegal_op", 32'(illegal_op), 32'(m_ill));
`endif
      @(posedge clk);
      model_step(mr, op);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_mem_write", 32'(mem_write), 0);
      chk("rst_mem_err", 32'(mem_err), 0);
      m_st = 0; m_wait = 0; m_err = 0; m_ill = 0;
      plan.delete();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [5:0] pick_op();
      case ($urandom_range(7))
         0: return LW;
         1: return SW;
         2: return RT;
         3: return BEQ;
         4: return ADDI;
         5: return J;
         default: return 6'b110000 | 6'($urandom_range(15));
      endcase
   endfunction

   int lw_seq[6] = '{0, 1, 2, 3, 4, 0};
   logic [5:0] r_op;

   initial begin
      #1;
      chk("reset_outputs", 32'(dut_vec), 32'(exp_vec(0, 1'b0, 1'b0, 1'b0)));
      chk("reset_mem_req", 32'(mem_req), 1);
      @(negedge clk);
      reset = 1'b0;

      // lw with mem_ready held high: five-cycle sequence.
      for (int i = 0; i < 6; i++) begin
         chk("lw_state", 32'(state), 32'(lw_seq[i]));
         chk("lw_reg_write", 32'(reg_write), (i == 4) ? 1 : 0);
         if (i < 5) cycle(1'b1, 1'b0, LW);
      end

      // beq taken and not taken.
      for (int t = 0; t < 2; t++) begin
         do_reset();
         cycle(1'b1, 1'b0, BEQ);
         cycle(1'b1, 1'b0, BEQ);
         chk("beq_state", 32'(state), 8);
         zero = (t == 0);
         #1;
         chk("beq_pc_en", 32'(pc_en), (t == 0) ? 1 : 0);
         chk("beq_pc_src", 32'(pc_src), 1);
         chk("beq_alu_op", 32'(alu_op), 1);
         cycle(1'b1, t == 0, BEQ);
         chk("beq_back", 32'(state), 0);
      end

      // MEMRD with three wait cycles under a limit of four: no error.
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, LW);
      for (int i = 0; i < 3; i++) begin
         chk("memrd_wait_state", 32'(state), 3);
         chk("memrd_wait_req", 32'(mem_req), 1);
         cycle(1'b0, 1'b0, LW);
      end
      chk("memrd_last_state", 32'(state), 3);
      cycle(1'b1, 1'b0, LW);
      chk("memrd_done_state", 32'(state), 4);
      chk("memrd_no_err", 32'(mem_err), 0);

      // Stuck fetch: fourth wait cycle times out into HALT.
      do_reset();
      for (int i = 0; i < TO; i++) begin
         chk("to_fetch_state", 32'(state), 0);
         cycle(1'b0, 1'b0, LW);
      end
      chk("to_state", 32'(state), 15);
      chk("to_halted", 32'(halted), 1);
      chk("to_mem_err", 32'(mem_err), 1);
      cycle(1'b1, 1'b0, LW);
      chk("to_stays_halted", 32'(state), 15);
      do_reset();
      chk("to_cleared_halted", 32'(halted), 0);

      // Unknown opcode.
      cycle(1'b1, 1'b0, 6'b111111);
      chk("illop_decode", 32'(state), 1);
      cycle(1'b1, 1'b0, 6'b111111);
`ifdef ILLEGAL_OP_TRAP_EN
      chk("illop_halt", 32'(state), 15);
      chk("illop_flag", 32'(illegal_op), 1);
      do_reset();
      chk("illop_flag_clr", 32'(illegal_op), 0);
`else
      chk("illop_nop", 32'(state), 0);
`endif

      // Reset during a MEMWR wait; the counter must restart for the next fetch.
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, SW);
      chk("sw_memwr", 32'(state), 5);
      cycle(1'b0, 1'b0, SW);
      cycle(1'b0, 1'b0, SW);
      do_reset();
      for (int i = 0; i < TO - 1; i++) cycle(1'b0, 1'b0, LW);
      cycle(1'b1, 1'b0, LW);
      chk("post_rst_fetch", 32'(state), 1);
      chk("post_rst_no_err", 32'(mem_err), 0);

      // Randomized traffic.
      do_reset();
      r_op = LW;
      for (int i = 0; i < 4000; i++) begin
         if (m_st == 0) r_op = pick_op();
         if ((m_st == 15 && $urandom_range(3) == 0) || $urandom_range(199) == 0) do_reset();
         else cycle($urandom_range(99) < 65, 1'($urandom_range(1)), r_op);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
